uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered 8N1/8N2 UART transmitter: byte FIFO on a valid/ready write port,
//  hardware flow control (cts_n) and an internal bit-time counter. Sits between
//  host-side logic and the FT232 TX pin, so producers can burst bytes without
//  polling a per-byte ready. LSB first, idle-high line.
// PARAMETERS
//  DIVISOR    100  clk cycles per bit time; >= 2
//  ADDR_W     4    FIFO depth = 2**ADDR_W bytes
//  STOP_BITS  1    stop bits per frame; 1 or 2
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-high reset
//  data        in   8         byte to enqueue
//  data_valid  in   1         data is presented this cycle
//  data_ready  out  1         FIFO not full; write accepted when valid&&ready
//  cts_n       in   1         async clear-to-send, active low; 2-flop synced inside
//  serial      out  1         UART line, registered, idle 1
//  busy        out  1         FIFO non-empty or frame in progress
//  fifo_level  out  ADDR_W+1  bytes currently queued (0..2**ADDR_W)
//  overflow    out  1         sticky: a write was offered while full
// BEHAVIOUR
//  Reset (sync, takes priority over everything): serial=1, data_ready=1, busy=0,
//   fifo_level=0, overflow=0, FSM=IDLE, FIFO pointers cleared, cts sync regs=1.
//   Reset mid-frame aborts the frame; serial is 1 the cycle after reset is sampled.
//  FIFO: write iff data_valid && data_ready; data_ready = !full (registered from
//   level). A write while full is dropped and sets overflow (cleared only by reset).
//   Pop only in IDLE when not empty; push+pop same cycle: level unchanged.
//   Pointers wrap modulo 2**ADDR_W; level ADDR_W+1 bits, full = level==2**ADDR_W.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: if !empty && cts_sync==0 -> pop, load shifter, baud_cnt=0, serial<=0,
//         go START. Otherwise serial<=1.
//   Each state bit lasts exactly DIVISOR clocks; baud_cnt counts 0..DIVISOR-1,
//   runs only outside IDLE so the start edge aligns with the pop.
//   START -> DATA after DIVISOR clocks; DATA shifts 8 bits LSB first, bit_idx 0..7.
//   STOP: serial=1 for STOP_BITS*DIVISOR clocks, then re-evaluate as IDLE in the
//   same cycle: if next byte ready and cts ok, next start bit follows with no gap.
//  Frame length: (9+STOP_BITS)*DIVISOR clocks exactly.
//  Latency: byte written at edge T into empty FIFO with cts_sync=0 -> serial low
//   after edge T+1. cts_n falling -> start after at most 3 edges (2 sync + 1).
//  cts_n checked only in IDLE; deassertion mid-frame lets current frame finish.
//  busy = (state!=IDLE) || (level!=0), combinational from registers.
// TESTING (DIVISOR=4 unless noted)
//  1 cts_n=0, write 0x55 -> serial low 4 clk, then 1,0,1,0,1,0,1,0 each 4 clk,
//    high 4 clk; busy falls at end of stop bit; level 1->0 on pop.
//  2 write 0x00,0xFF,0xA5 on consecutive cycles -> three contiguous frames,
//    120 clk total, no idle cycle between stop and next start.
//  3 ADDR_W=2, cts_n=1, write 5 bytes -> level=4, data_ready=0 after 4th,
//    5th dropped, overflow=1, serial stays 1.
//  4 from 3, drop cts_n -> start bit within 3 clk; raise cts_n in bit 2 of frame 1
//    -> frame 1 completes, line idles, level=3 holds until cts_n low again.
//  5 reset during data bit 3 -> next clk serial=1, level=0, data_ready=1,
//    overflow=0; no output after release until a new write.
//  6 STOP_BITS=2, write 0x80 -> frame 44 clk, bit7=1, stop high 8 clk.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1/8N2 UART transmitter with byte FIFO and cts_n flow control
module uart_tx_fifo #(
  parameter int DIVISOR   = 100,
  parameter int ADDR_W    = 4,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      data,
  input  logic            data_valid,
  output logic            data_ready,
  input  logic            cts_n,
  output logic            serial,
  output logic            busy,
  output logic [ADDR_W:0] fifo_level,
  output logic            overflow
);
  localparam int BW = $clog2(DIVISOR);
  localparam logic [BW-1:0] BAUD_MAX = BW'(DIVISOR - 1);
  localparam logic [2:0] STOP_MAX = 3'(STOP_BITS - 1);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] level_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shifter, shift_n;
  logic serial_n, cts_meta, cts_sync, push, pop, baud_last, go;
  assign push = data_valid && data_ready;
  assign baud_last = baud_cnt == BAUD_MAX;
  assign go = fifo_level != '0 && !cts_sync;
  assign level_n = fifo_level + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
  assign busy = state != IDLE || fifo_level != '0;
  always_comb begin
    state_n = state;
    baud_n = (state == IDLE || baud_last) ? '0 : baud_cnt + 1'b1;
    bit_n = bit_idx;
    shift_n = shifter;
    serial_n = serial;
    pop = 1'b0;
    case (state)
      IDLE: serial_n = 1'b1;
      START:
        if (baud_last) begin
          state_n = DATA;
          bit_n = '0;
          serial_n = shifter[0];
          shift_n = shifter >> 1;
        end
      DATA:
        if (baud_last) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            bit_n = '0;
            serial_n = 1'b1;
          end else begin
            bit_n = bit_idx + 1'b1;
            serial_n = shifter[0];
            shift_n = shifter >> 1;
          end
        end
      STOP:
        if (baud_last) begin
          if (bit_idx == STOP_MAX) begin
            state_n = IDLE;
            serial_n = 1'b1;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      default: state_n = IDLE;
    endcase
    // The end of the last stop bit is evaluated as IDLE so back-to-back frames have no gap
    if (state_n == IDLE && go) begin
      pop = 1'b1;
      shift_n = mem[rd_ptr];
      state_n = START;
      serial_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
      serial <= 1'b1;
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      data_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_idx <= bit_n;
      shifter <= shift_n;
      serial <= serial_n;
      cts_meta <= cts_n;
      cts_sync <= cts_meta;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_n;
      data_ready <= level_n != FULL;
      overflow <= overflow | (data_valid & ~data_ready);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= data;
endmodule
